// File: rtl/sprite_compositor_if.sv
// Pixel, sprite, map-ROM and composited-output signals of the sprite compositor.
// The master side drives the scan, sprite table and ROM data; the slave is the compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPR = 4
);
  logic [10:0]          x;
  logic [10:0]          y;
  logic                 pix_valid;
  logic                 frame_start;
  logic [NUM_SPR*9-1:0] spr_x;
  logic [NUM_SPR*9-1:0] spr_y;
  logic [NUM_SPR-1:0]   spr_en;
  logic [NUM_SPR*8-1:0] spr_color;
  logic [4:0]           tile_x;
  logic [5:0]           tile_y;
  logic [1:0]           tile_code;
  logic [7:0]           rgb;
  logic                 rgb_valid;
  logic [NUM_SPR-1:0]   collide;

  modport master (
    output x, y, pix_valid, frame_start, spr_x, spr_y, spr_en, spr_color, tile_code,
    input  tile_x, tile_y, rgb, rgb_valid, collide
  );

  modport slave (
    input  x, y, pix_valid, frame_start, spr_x, spr_y, spr_en, spr_color, tile_code,
    output tile_x, tile_y, rgb, rgb_valid, collide
  );
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: map-window test and tile addressing, sprite hit test
// against per-frame shadow registers, then priority colour selection with pellet blink.
module sprite_compositor #(
  parameter int         NUM_SPR      = 4,
  parameter int         SPR_W        = 24,
  parameter int         MAP_LU_X     = 150,
  parameter int         MAP_LU_Y     = 50,
  parameter int         MAP_RD_X     = 498,
  parameter int         MAP_RD_Y     = 458,
  parameter logic [7:0] COLOR_NULL   = 8'h00,
  parameter logic [7:0] COLOR_WALL   = 8'h03,
  parameter logic [7:0] COLOR_DOT    = 8'hFC,
  parameter logic [7:0] COLOR_PELLET = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  sprite_compositor_if.slave   bus
);

  localparam logic [11:0] HALF = 12'(SPR_W / 2);

  // S0 combinational: window test and map-relative offsets
  logic       w_in_map;
  logic [8:0] w_mx;
  logic [8:0] w_my;

  assign w_in_map = (bus.x >= 11'(MAP_LU_X)) && (bus.x < 11'(MAP_RD_X)) &&
                    (bus.y >= 11'(MAP_LU_Y)) && (bus.y < 11'(MAP_RD_Y));
  assign w_mx     = 9'(bus.x - 11'(MAP_LU_X));
  assign w_my     = 9'(bus.y - 11'(MAP_LU_Y));

  logic       r0_valid;
  logic       r0_in_map;
  logic [8:0] r0_mx;
  logic [8:0] r0_my;
  logic [4:0] r_tile_x;
  logic [5:0] r_tile_y;

  // S0 register stage, including the map-ROM address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_valid  <= 1'b0;
      r0_in_map <= 1'b0;
      r0_mx     <= 9'd0;
      r0_my     <= 9'd0;
      r_tile_x  <= 5'd0;
      r_tile_y  <= 6'd0;
    end else begin
      r0_valid  <= bus.pix_valid;
      r0_in_map <= w_in_map;
      r0_mx     <= w_mx;
      r0_my     <= w_my;
      r_tile_x  <= w_in_map ? 5'(w_mx / 9'd12) : 5'd0;
      r_tile_y  <= w_in_map ? 6'(w_my / 9'd12) : 6'd0;
    end
  end

  logic [NUM_SPR*9-1:0] r_sh_x;
  logic [NUM_SPR*9-1:0] r_sh_y;
  logic [NUM_SPR-1:0]   r_sh_en;
  logic [NUM_SPR*8-1:0] r_sh_col;
  logic [4:0]           r_blink;

  // Sprite shadow registers and blink counter, both advanced only at frame boundaries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_x   <= '0;
      r_sh_y   <= '0;
      r_sh_en  <= '0;
      r_sh_col <= '0;
      r_blink  <= 5'd0;
    end else if (bus.frame_start) begin
      r_sh_x   <= bus.spr_x;
      r_sh_y   <= bus.spr_y;
      r_sh_en  <= bus.spr_en;
      r_sh_col <= bus.spr_color;
      r_blink  <= r_blink + 5'd1;
    end else begin
      r_sh_x   <= r_sh_x;
      r_sh_y   <= r_sh_y;
      r_sh_en  <= r_sh_en;
      r_sh_col <= r_sh_col;
      r_blink  <= r_blink;
    end
  end

  logic [NUM_SPR-1:0] w_hit;
  logic [NUM_SPR-1:0] w_coll;
  logic               w_any_hit;
  logic [7:0]         w_hit_col;

  // S1 hit test; 12-bit compares keep centres near the map edge from wrapping.
  // Scanning from the top index down lets the lowest-index hit win the colour.
  always_comb begin
    w_hit     = '0;
    w_coll    = '0;
    w_any_hit = 1'b0;
    w_hit_col = COLOR_NULL;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      if (r_sh_en[k] && r0_in_map &&
          (({3'b000, r0_mx} + HALF) >= {3'b000, r_sh_x[k*9 +: 9]}) &&
          ({3'b000, r0_mx} < ({3'b000, r_sh_x[k*9 +: 9]} + HALF)) &&
          (({3'b000, r0_my} + HALF) >= {3'b000, r_sh_y[k*9 +: 9]}) &&
          ({3'b000, r0_my} < ({3'b000, r_sh_y[k*9 +: 9]} + HALF))) begin
        w_hit[k]  = 1'b1;
        w_any_hit = 1'b1;
        w_hit_col = r_sh_col[k*8 +: 8];
      end else begin
        w_hit[k]  = 1'b0;
      end
    end
    for (int k = 1; k < NUM_SPR; k++) begin
      w_coll[k] = r0_valid & w_hit[0] & w_hit[k];
    end
  end

  logic       r1_valid;
  logic       r1_in_map;
  logic       r1_any_hit;
  logic [7:0] r1_col;

  // S1 register stage; the winning sprite colour travels with the pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_valid   <= 1'b0;
      r1_in_map  <= 1'b0;
      r1_any_hit <= 1'b0;
      r1_col     <= COLOR_NULL;
    end else begin
      r1_valid   <= r0_valid;
      r1_in_map  <= r0_in_map;
      r1_any_hit <= w_any_hit;
      r1_col     <= w_hit_col;
    end
  end

  logic [NUM_SPR-1:0] r_acc;
  logic [NUM_SPR-1:0] r_collide;

  // Collision accumulator; a hit on the boundary cycle seeds the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_collide <= '0;
    end else if (bus.frame_start) begin
      r_collide <= r_acc;
      r_acc     <= w_coll;
    end else begin
      r_collide <= r_collide;
      r_acc     <= r_acc | w_coll;
    end
  end

  logic [7:0] w_tile_col;
  logic [7:0] w_rgb;

  // S2 colour select; ROM data lines up with the S1 register contents
  always_comb begin
    w_tile_col = COLOR_NULL;
    case (bus.tile_code)
      2'd0:    w_tile_col = COLOR_WALL;
      2'd1:    w_tile_col = COLOR_NULL;
      2'd2:    w_tile_col = COLOR_DOT;
      2'd3:    w_tile_col = r_blink[4] ? COLOR_NULL : COLOR_PELLET;
      default: w_tile_col = COLOR_NULL;
    endcase
    w_rgb = COLOR_NULL;
    if (!r1_valid || !r1_in_map) begin
      w_rgb = COLOR_NULL;
    end else if (r1_any_hit) begin
      w_rgb = r1_col;
    end else begin
      w_rgb = w_tile_col;
    end
  end

  logic [7:0] r_rgb;
  logic       r_rgb_valid;

  // S2 output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb       <= COLOR_NULL;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb       <= w_rgb;
      r_rgb_valid <= r1_valid;
    end
  end

  assign bus.tile_x    = r_tile_x;
  assign bus.tile_y    = r_tile_y;
  assign bus.rgb       = r_rgb;
  assign bus.rgb_valid = r_rgb_valid;
  assign bus.collide   = r_collide;

endmodule
